// File: rtl/raster_cmd_arbiter.sv
//------------------------------------------------------------------------------
// raster_cmd_arbiter
//
// Purpose:
//   Arbitrates rectangle-draw commands from two requesters onto a single
//   rasterizer command port. Each requester owns a private 2-entry FIFO.
//   Whenever the arbiter is idle it pops one command (round-robin when both
//   FIFOs hold work). It then presents the command with a one-cycle cmd_ready
//   strobe and waits for the rasterizer's frame_sync pulse. After frame_sync
//   it holds off for DRAIN_CYCLES while the rasterizer streams pixels. If
//   frame_sync never arrives, the sticky timeout_err flag is raised and the
//   arbiter returns to idle.
//
// Parameters:
//   DRAIN_CYCLES  cycles the rasterizer streams pixels after frame_sync
//   SYNC_TIMEOUT  cycles after cmd_ready within which frame_sync is expected
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0_valid/req0_data      requester 0 command offer (20-bit packed)
//   req0_ready                requester 0 FIFO can accept
//   req1_valid/req1_data      requester 1 command offer (20-bit packed)
//   req1_ready                requester 1 FIFO can accept
//   out_cmd .. out_height     command fields presented to the rasterizer
//   cmd_ready                 one-cycle issue strobe
//   frame_sync                rasterizer draw-complete pulse
//   busy                      a command is in flight
//   grant_id                  requester of the most recently issued command
//   issued_count              number of issued commands, wraps at 256
//   timeout_err               sticky frame_sync timeout flag
//------------------------------------------------------------------------------

//------------------------------------------------------------------------------
// raster_cmd_fifo
//
// Purpose:
//   Two-entry FIFO holding one requester's pending commands.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_push     write i_data (caller guarantees FIFO is not full)
//   i_data     entry to write
//   i_pop      drop the head entry (caller guarantees FIFO is not empty)
//   o_data     head entry
//   o_empty    no entries held
//   o_full     both entries held
//------------------------------------------------------------------------------
module raster_cmd_fifo #(
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full
);

    logic [DATA_W-1:0] r_mem0;
    logic [DATA_W-1:0] r_mem1;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    // Storage carries no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            if (r_wptr) begin
                r_mem1 <= i_data;
            end else begin
                r_mem0 <= i_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_wptr <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_rptr ? r_mem1 : r_mem0;
    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);

endmodule

module raster_cmd_arbiter #(
    parameter int DRAIN_CYCLES = 64,
    parameter int SYNC_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [19:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [19:0] req1_data,
    output logic        req1_ready,
    output logic [1:0]  out_cmd,
    output logic [2:0]  out_x1,
    output logic [2:0]  out_y1,
    output logic [2:0]  out_x2,
    output logic [2:0]  out_y2,
    output logic [2:0]  out_width,
    output logic [2:0]  out_height,
    output logic        cmd_ready,
    input  logic        frame_sync,
    output logic        busy,
    output logic        grant_id,
    output logic [7:0]  issued_count,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int TMO_W   = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT + 1) : 1;

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(SYNC_TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [19:0]        r_out;
    logic               r_grant_id;
    logic               r_last_grant;
    logic [7:0]         r_issued;
    logic               r_timeout_err;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;

    logic        w_empty0;
    logic        w_empty1;
    logic        w_full0;
    logic        w_full1;
    logic [19:0] w_head0;
    logic [19:0] w_head1;
    logic        w_push0;
    logic        w_push1;
    logic        w_any;
    logic        w_sel;
    logic        w_pop0;
    logic        w_pop1;
    logic [19:0] w_sel_data;
    logic [TMO_W-1:0] w_tmo_next;

    // Ready depends only on registered occupancy, so a full FIFO refuses a
    // push even in the cycle it is being popped.
    assign w_push0 = req0_valid & ~w_full0;
    assign w_push1 = req1_valid & ~w_full1;

    raster_cmd_fifo #(.DATA_W(20)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push0),
        .i_data  (req0_data),
        .i_pop   (w_pop0),
        .o_data  (w_head0),
        .o_empty (w_empty0),
        .o_full  (w_full0)
    );

    raster_cmd_fifo #(.DATA_W(20)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_data  (req1_data),
        .i_pop   (w_pop1),
        .o_data  (w_head1),
        .o_empty (w_empty1),
        .o_full  (w_full1)
    );

    // Round-robin: with both FIFOs holding work the requester that did not
    // win last time goes next; otherwise whichever one has work wins.
    always_comb begin
        w_any = ~w_empty0 | ~w_empty1;
        if (~w_empty0 && ~w_empty1) begin
            w_sel = ~r_last_grant;
        end else begin
            w_sel = w_empty0;
        end
        w_pop0     = (r_state == S_IDLE) && w_any && ~w_sel;
        w_pop1     = (r_state == S_IDLE) && w_any &&  w_sel;
        w_sel_data = w_sel ? w_head1 : w_head0;
    end

    // The timeout fires as the counter would reach SYNC_TIMEOUT-1, which puts
    // timeout_err high exactly SYNC_TIMEOUT cycles after the cmd_ready strobe.
    assign w_tmo_next = r_tmo_cnt + TMO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_out         <= 20'd0;
            r_grant_id    <= 1'b0;
            r_last_grant  <= 1'b1;
            r_issued      <= 8'd0;
            r_timeout_err <= 1'b0;
            r_tmo_cnt     <= '0;
            r_drain_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Command fields only ever change here, so they stay
                    // stable for the rasterizer's late sample after cmd_ready.
                    if (w_any) begin
                        r_out        <= w_sel_data;
                        r_grant_id   <= w_sel;
                        r_last_grant <= w_sel;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_issued  <= r_issued + 8'd1;
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (frame_sync) begin
                        r_drain_cnt <= DRAIN_LOAD;
                        r_state     <= S_DRAIN;
                    end else if (w_tmo_next == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
                end
                S_DRAIN: begin
                    // frame_sync is deliberately ignored while draining.
                    if (r_drain_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready   = ~w_full0;
    assign req1_ready   = ~w_full1;

    assign out_cmd      = r_out[19:18];
    assign out_x1       = r_out[17:15];
    assign out_y1       = r_out[14:12];
    assign out_x2       = r_out[11:9];
    assign out_y2       = r_out[8:6];
    assign out_width    = r_out[5:3];
    assign out_height   = r_out[2:0];

    assign cmd_ready    = (r_state == S_ISSUE);
    assign busy         = (r_state != S_IDLE);
    assign grant_id     = r_grant_id;
    assign issued_count = r_issued;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_raster_cmd_arbiter.sv
module tb_raster_cmd_arbiter;

  localparam int DRAIN = 64;
  localparam int TMO   = 8;
  localparam int INF   = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0;
  logic        v1 = 1'b0;
  logic [19:0] d0 = 20'd0;
  logic [19:0] d1 = 20'd0;
  logic        fs = 1'b0;
  logic        fs_force = 1'b0;

  logic        req0_ready, req1_ready;
  logic [1:0]  out_cmd;
  logic [2:0]  out_x1, out_y1, out_x2, out_y2, out_width, out_height;
  logic        cmd_ready, busy, grant_id, timeout_err;
  logic [7:0]  issued_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_delay = 0;
  int fs_cnt = -1;

  raster_cmd_arbiter #(.DRAIN_CYCLES(DRAIN), .SYNC_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (v0),
    .req0_data    (d0),
    .req0_ready   (req0_ready),
    .req1_valid   (v1),
    .req1_data    (d1),
    .req1_ready   (req1_ready),
    .out_cmd      (out_cmd),
    .out_x1       (out_x1),
    .out_y1       (out_y1),
    .out_x2       (out_x2),
    .out_y2       (out_y2),
    .out_width    (out_width),
    .out_height   (out_height),
    .cmd_ready    (cmd_ready),
    .frame_sync   (fs),
    .busy         (busy),
    .grant_id     (grant_id),
    .issued_count (issued_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: queues per requester plus the cycle of the last
  // issue and the first cycle the arbiter is free again.
  logic [19:0] mq0[$];
  logic [19:0] mq1[$];
  int          t_idle = 0;
  int          t_issue = -1000;
  logic        m_last = 1'b1;
  logic        m_gid = 1'b0;
  logic        m_err = 1'b0;
  logic [7:0]  m_cnt = 8'd0;
  logic [19:0] m_out = 20'd0;

  always @(posedge clk or posedge rst) begin
    int p;
    int n;
    int sz0;
    int sz1;
    bit idle_p;
    logic sel;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      t_idle  = 0;
      t_issue = -1000;
      m_last  = 1'b1;
      m_gid   = 1'b0;
      m_err   = 1'b0;
      m_cnt   = 8'd0;
      m_out   = 20'd0;
    end else begin
      p = cyc;
      n = cyc + 1;
      sz0 = mq0.size();
      sz1 = mq1.size();
      idle_p = (p >= t_idle);
      if (t_issue == p) m_cnt = m_cnt + 8'd1;
      if (t_idle == INF) begin
        if (fs && p > t_issue) t_idle = p + DRAIN + 1;
        else if (p == t_issue + TMO - 1) begin
          m_err  = 1'b1;
          t_idle = n;
        end
      end
      if (idle_p && (sz0 > 0 || sz1 > 0)) begin
        if (sz0 > 0 && sz1 > 0) sel = ~m_last;
        else sel = (sz0 == 0);
        m_out   = sel ? mq1.pop_front() : mq0.pop_front();
        m_gid   = sel;
        m_last  = sel;
        t_issue = n;
        t_idle  = INF;
      end
      if (v0 && sz0 < 2) mq0.push_back(d0);
      if (v1 && sz1 < 2) mq1.push_back(d1);
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, t_issue == cyc);
    chk("busy", busy, cyc < t_idle);
    chk("grant_id", grant_id, m_gid);
    chk("issued_count", issued_count, m_cnt);
    chk("timeout_err", timeout_err, m_err);
    chk("req0_ready", req0_ready, mq0.size() < 2);
    chk("req1_ready", req1_ready, mq1.size() < 2);
    chk("out_fields", {out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height}, m_out);
  end

  // Rasterizer stand-in: answers each cmd_ready with frame_sync fs_delay
  // cycles later (never when fs_delay is 0); fs_force adds extra pulses.
  always @(negedge clk) begin
    #2;
    fs = fs_force;
    if (rst) fs_cnt = -1;
    else if (cmd_ready && fs_delay > 0) fs_cnt = fs_delay;
    else if (fs_cnt > 0) begin
      fs_cnt = fs_cnt - 1;
      if (fs_cnt == 0) begin
        fs = 1'b1;
        fs_cnt = -1;
      end
    end
  end

  task automatic wait_cycles(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int r, input logic [19:0] d, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (r == 0) begin v0 = 1'b1; d0 = d; end
      else begin v1 = 1'b1; d1 = d; end
      ok = (r == 0) ? req0_ready : req1_ready;
      acc_cyc = cyc;
      @(negedge clk);
      #1;
    end
    if (r == 0) v0 = 1'b0; else v1 = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push%0d: accepted 0 required 1 within 300 cycles", r);
    end
  endtask

  task automatic wait_issue(output int ic, output logic g);
    bit found;
    found = 1'b0;
    ic = -1;
    g = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (cmd_ready === 1'b1) begin
        found = 1'b1;
        ic = cyc;
        g = grant_id;
      end
      @(negedge clk);
      #1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_issue: cmd_ready seen 0 required 1 within 400 cycles");
    end
  endtask

  task automatic wait_idle();
    int run;
    run = 0;
    for (int k = 0; k < 3000 && run < 4; k++) begin
      if (busy === 1'b0) run++;
      else run = 0;
      @(negedge clk);
      #1;
    end
    if (run < 4) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: idle 0 required 1 within 3000 cycles");
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: finished 0 required 1");
    $fatal(1, "watchdog");
  end

  int   pa, pc, pd, a4, t, t0, t1, i1, i2, id, ig, ix;
  logic g;

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    chk("rst_count", issued_count, 0);
    chk("rst_ready0", req0_ready, 1);

    // Single command, frame_sync 3 cycles after issue, second one waiting.
    fs_delay = 3;
    push(0, {2'b01, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, pa);
    push(0, {2'b10, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2}, t);
    wait_issue(i1, g);
    chk("A_latency", i1, pa + 2);
    chk("A_x1", out_x1, 2);
    chk("A_y1", out_y1, 3);
    chk("A_cmd", out_cmd, 1);
    wait_cycles(10);
    fs_force = 1'b1;
    wait_cycles(1);
    fs_force = 1'b0;
    wait_issue(i2, g);
    chk("A_next_issue", i2, i1 + 3 + 66);
    wait_idle();
    fs_force = 1'b1;
    wait_cycles(1);
    fs_force = 1'b0;
    wait_cycles(3);

    // Back-to-back pushes to req0 while busy: third one held off.
    push(0, 20'h4_1111, pc);
    push(0, 20'h8_2222, t);
    push(0, 20'hC_3333, t);
    chk("C_ready_full", req0_ready, 0);
    push(0, 20'h0_4444, a4);
    chk("C_third_accept", a4, pc + 71);
    wait_idle();

    // No frame_sync: timeout, then the queued command issues.
    fs_delay = 0;
    push(1, 20'h5_5555, pd);
    push(1, 20'hA_AAAA, t);
    wait_issue(id, g);
    chk("D_gid", g, 1);
    wait_cycles(6);
    chk("D_err_early", timeout_err, 0);
    wait_cycles(1);
    chk("D_err", timeout_err, 1);
    chk("D_idle", busy, 0);
    wait_issue(i2, g);
    chk("D_next_issue", i2, id + 9);
    wait_idle();
    chk("D_sticky", timeout_err, 1);

    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    chk("R_err_clear", timeout_err, 0);

    // Both FIFOs full at once: alternating issue order.
    fs_delay = 2;
    push(1, 20'h1_0001, t);
    wait_issue(ig, g);
    chk("B_first_gid", g, 1);
    fork
      begin push(0, 20'h2_0002, t0); push(0, 20'h3_0003, t0); end
      begin push(1, 20'h4_0004, t1); push(1, 20'h5_0005, t1); end
    join
    chk("B_full0", req0_ready, 0);
    chk("B_full1", req1_ready, 0);
    for (int k = 0; k < 4; k++) begin
      wait_issue(ix, g);
      chk("B_order", g, k % 2);
    end
    wait_idle();
    chk("B_count", issued_count, 5);

    // Reset during DRAIN with both FIFOs holding work.
    fs_delay = 3;
    push(0, 20'h6_0006, t);
    fork
      begin push(0, 20'h7_0007, t0); push(0, 20'h8_0008, t0); end
      begin push(1, 20'h9_0009, t1); push(1, 20'hA_000A, t1); end
    join
    wait_cycles(8);
    chk("E_busy_before", busy, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("E_rst_busy", busy, 0);
    chk("E_rst_cmd_ready", cmd_ready, 0);
    chk("E_rst_out", {out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height}, 0);
    chk("E_rst_count", issued_count, 0);
    chk("E_rst_gid", grant_id, 0);
    chk("E_rst_ready0", req0_ready, 1);
    chk("E_rst_ready1", req1_ready, 1);
    @(negedge clk);
    #1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(20);
    chk("E_no_issue", issued_count, 0);
    chk("E_idle", busy, 0);

    // 256 commands through the timeout path: counter wraps to 0.
    fs_delay = 0;
    for (int k = 0; k < 256; k++) begin
      push(k % 2, 20'($urandom), t);
    end
    wait_idle();
    chk("F_wrap", issued_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
